alu2_issue_arbiter: RTL and testbench
=====================================

ALU2_ISSUE_ARBITER -- requirements
Module: alu2_issue_arbiter

Interface
REQ-001 Parameters: none; all widths below are fixed.
REQ-002 iCLOCK  in  1  system clock, all state updates on rising edge.
REQ-003 inRESET  in  1  asynchronous, active-low reset.
REQ-004 iFREE_EX  in  1  pipeline flush, synchronous, highest priority after reset.
REQ-005 iREQ0_VALID / iREQ1_VALID  in  1 each  requester n holds an issue-ready ALU2 operation.
REQ-006 iREQ0_DATA / iREQ1_DATA  in  96 each  operation bundle: [95:90] commit tag, [89:85] cmd, [84:81] afe, [80:77] unit one-hot {sysreg,logic,shift,adder}, [76:45] source0, [44:13] source1, [12] dest sysreg, [11:6] dest regname, [5] writeback, [4] flags writeback, [3:0] flags regname.
REQ-007 oREQ0_ACK / oREQ1_ACK  out  1 each  combinational; requester n's bundle is captured at this edge.
REQ-008 oEX_VALID  out  1  registered operation valid toward ALU2 port.
REQ-009 oEX_DATA  out  96  registered bundle, same layout as REQ-006.
REQ-010 iEX_LOCK  in  1  ALU2 port cannot accept this cycle.
REQ-011 oSTATE  out  2  0=IDLE, 1=ISSUE, 2=STALL.
REQ-012 oISSUE_COUNT  out  16  completed transfers, wraps.
REQ-013 oSTALL_COUNT  out  8  cycles with oEX_VALID=1 and iEX_LOCK=1, saturates at 8'hFF.

Function
REQ-014 Transfer SHALL occur on an edge where oEX_VALID=1 and iEX_LOCK=0.
REQ-015 load = !iFREE_EX && (!oEX_VALID || !iEX_LOCK); evaluated combinationally each cycle.
REQ-016 Grant: one requester valid -> it wins; both valid -> requester indexed by rr_ptr wins; none -> no grant.
REQ-017 oREQn_ACK SHALL equal load && (grant==n); at most one ACK high per cycle; both 0 while iFREE_EX=1.
REQ-018 On load with grant: oEX_VALID<=1, oEX_DATA<=winner bundle, rr_ptr<=~winner, state<=ISSUE.
REQ-019 On load without grant: oEX_VALID<=0, oEX_DATA held, state<=IDLE.
REQ-020 No load (valid and locked): oEX_VALID, oEX_DATA, rr_ptr held; state<=STALL.
REQ-021 Latency: ACK edge to oEX_VALID=1 is one cycle; back-to-back issue at one op/cycle while iEX_LOCK=0.
REQ-022 Lock release in STALL: the held op transfers and a new grant loads in the same edge (no bubble).
REQ-023 iFREE_EX=1 at edge: oEX_VALID<=0, oEX_DATA<=0, rr_ptr<=0, state<=IDLE; counters unchanged; held op discarded.
REQ-024 oISSUE_COUNT increments by 1 per transfer (REQ-014), 16'hFFFF+1 -> 0; a transfer on an iFREE_EX edge still counts.
REQ-025 oSTALL_COUNT increments per cycle of oEX_VALID&&iEX_LOCK, holds at 8'hFF.
REQ-026 Bundle SHALL pass unmodified; unit one-hot not checked.
REQ-027 Requester n SHALL keep iREQn_VALID/DATA stable until ACK; block does not store unacked requests.

Reset
REQ-028 inRESET=0 SHALL asynchronously force oEX_VALID=0, oEX_DATA=0, rr_ptr=0, oSTATE=IDLE, oISSUE_COUNT=0, oSTALL_COUNT=0; ACKs 0 while in reset.
REQ-029 Reset mid-STALL SHALL discard the held op with no transfer counted.

Verification
REQ-030 Both requesters valid 4 cycles, lock 0, tags 0x01 (req0) / 0x02 (req1) -> ACK0,ACK1,ACK0,ACK1; oEX_DATA tags 01,02,01,02 one cycle later; oISSUE_COUNT=4.
REQ-031 req0 issued tag 0x05, iEX_LOCK=1 for 3 cycles -> oSTATE=STALL, oEX_DATA stable, no ACK, oSTALL_COUNT=3; lock drops with req1 valid tag 0x06 -> same edge transfers 0x05 and loads 0x06.
REQ-032 iFREE_EX pulsed during STALL with both requesters valid -> ACKs 0, next cycle oEX_VALID=0, oSTATE=IDLE, rr_ptr=0; following cycle ACK0=1.
REQ-033 Lock held 300 cycles with valid op -> oSTALL_COUNT stops at 8'hFF.
REQ-034 Preload 65535 transfers then one more -> oISSUE_COUNT=0.
REQ-035 inRESET asserted asynchronously mid-ISSUE -> all outputs to REQ-028 values before next clock edge.

Source files
------------

// File: rtl/alu2_issue_arbiter.sv
// Two-requester round-robin issue arbiter feeding a single registered ALU2 port.
// Holds the issued op under iEX_LOCK, refills in the same edge the held op leaves.
module alu2_issue_arbiter (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iFREE_EX,
    input  logic        iREQ0_VALID,
    input  logic [95:0] iREQ0_DATA,
    input  logic        iREQ1_VALID,
    input  logic [95:0] iREQ1_DATA,
    output logic        oREQ0_ACK,
    output logic        oREQ1_ACK,
    output logic        oEX_VALID,
    output logic [95:0] oEX_DATA,
    input  logic        iEX_LOCK,
    output logic [1:0]  oSTATE,
    output logic [15:0] oISSUE_COUNT,
    output logic [7:0]  oSTALL_COUNT
);

    // Handshake: a requester holds VALID/DATA stable until its ACK; the bundle is
    // captured on the edge where ACK=1. Toward ALU2, an op leaves on the edge where
    // oEX_VALID=1 and iEX_LOCK=0.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        ex_valid_q, ex_valid_d;
    logic [95:0] ex_data_q, ex_data_d;
    logic        rr_ptr_q, rr_ptr_d;
    logic [15:0] issue_cnt_q, issue_cnt_d;
    logic [7:0]  stall_cnt_q, stall_cnt_d;

    logic        load;
    logic        grant_any;
    logic        grant_sel;
    logic        transfer;
    logic        stall_cycle;

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q     <= ST_IDLE;
            ex_valid_q  <= 1'b0;
            ex_data_q   <= '0;
            rr_ptr_q    <= 1'b0;
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ex_valid_q  <= ex_valid_d;
            ex_data_q   <= ex_data_d;
            rr_ptr_q    <= rr_ptr_d;
            issue_cnt_q <= issue_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ex_valid_d  = ex_valid_q;
        ex_data_d   = ex_data_q;
        rr_ptr_d    = rr_ptr_q;
        issue_cnt_d = issue_cnt_q;
        stall_cnt_d = stall_cnt_q;
        oREQ0_ACK   = 1'b0;
        oREQ1_ACK   = 1'b0;

        load        = !iFREE_EX && (!ex_valid_q || !iEX_LOCK);
        grant_any   = iREQ0_VALID || iREQ1_VALID;
        grant_sel   = (iREQ0_VALID && iREQ1_VALID) ? rr_ptr_q : iREQ1_VALID;
        transfer    = ex_valid_q && !iEX_LOCK;
        stall_cycle = ex_valid_q && iEX_LOCK;

        // Counters are statistics only; a flush does not clear them.
        if (transfer) begin
            issue_cnt_d = issue_cnt_q + 16'd1;
        end
        if (stall_cycle && (stall_cnt_q != 8'hFF)) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end

        if (iFREE_EX) begin
            ex_valid_d = 1'b0;
            ex_data_d  = '0;
            rr_ptr_d   = 1'b0;
            state_d    = ST_IDLE;
        end else if (load) begin
            if (grant_any) begin
                ex_valid_d = 1'b1;
                ex_data_d  = grant_sel ? iREQ1_DATA : iREQ0_DATA;
                rr_ptr_d   = !grant_sel;
                state_d    = ST_ISSUE;
                oREQ0_ACK  = inRESET && !grant_sel;
                oREQ1_ACK  = inRESET && grant_sel;
            end else begin
                ex_valid_d = 1'b0;
                state_d    = ST_IDLE;
            end
        end else begin
            state_d = ST_STALL;
        end
    end

    assign oEX_VALID    = ex_valid_q;
    assign oEX_DATA     = ex_data_q;
    assign oSTATE       = state_q;
    assign oISSUE_COUNT = issue_cnt_q;
    assign oSTALL_COUNT = stall_cnt_q;

endmodule

// File: tb/tb_alu2_issue_arbiter.sv
// Self-checking bench for alu2_issue_arbiter: directed scenarios plus random
// traffic against a behavioural model and an in-flight bundle scoreboard.
module tb_alu2_issue_arbiter;

    logic        clk;
    logic        rst_n;
    logic        free;
    logic        req0_v, req1_v;
    logic [95:0] req0_d, req1_d;
    logic        ack0, ack1;
    logic        ex_valid;
    logic [95:0] ex_data;
    logic        lock;
    logic [1:0]  state;
    logic [15:0] issue_count;
    logic [7:0]  stall_count;

    int n_checks;
    int n_errors;

    // Behavioural model of the visible state.
    logic        m_valid;
    logic [95:0] m_data;
    logic        m_rr;
    logic [1:0]  m_state;
    int          m_issue;
    int          m_stall;
    logic        last_ack0, last_ack1;
    logic [95:0] exp_q[$];

    alu2_issue_arbiter dut (
        .iCLOCK       (clk),
        .inRESET      (rst_n),
        .iFREE_EX     (free),
        .iREQ0_VALID  (req0_v),
        .iREQ0_DATA   (req0_d),
        .iREQ1_VALID  (req1_v),
        .iREQ1_DATA   (req1_d),
        .oREQ0_ACK    (ack0),
        .oREQ1_ACK    (ack1),
        .oEX_VALID    (ex_valid),
        .oEX_DATA     (ex_data),
        .iEX_LOCK     (lock),
        .oSTATE       (state),
        .oISSUE_COUNT (issue_count),
        .oSTALL_COUNT (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [95:0] make_bundle(input logic [5:0] tag);
        logic [95:0] b;
        b = {$urandom, $urandom, $urandom};
        b[95:90] = tag;
        return b;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_rr    = 1'b0;
        m_state = 2'd0;
        m_issue = 0;
        m_stall = 0;
        exp_q.delete();
    endtask

    task automatic check_reset_outputs();
        check("rst_valid", {95'd0, ex_valid}, 96'd0);
        check("rst_data", ex_data, 96'd0);
        check("rst_state", {94'd0, state}, 96'd0);
        check("rst_issue", {80'd0, issue_count}, 96'd0);
        check("rst_stall", {88'd0, stall_count}, 96'd0);
        check("rst_ack0", {95'd0, ack0}, 96'd0);
        check("rst_ack1", {95'd0, ack1}, 96'd0);
    endtask

    // Entered at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step();
        logic        any, win, ld, e0, e1;
        logic [95:0] wb, popped;
        #1;
        any = req0_v || req1_v;
        win = (req0_v && req1_v) ? m_rr : req1_v;
        ld  = !free && (!m_valid || !lock);
        e0  = ld && any && !win;
        e1  = ld && any && win;
        wb  = win ? req1_d : req0_d;
        check("ack0", {95'd0, ack0}, {95'd0, e0});
        check("ack1", {95'd0, ack1}, {95'd0, e1});
        if (m_valid && !lock) begin
            check("xfer_pending", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                popped = exp_q.pop_front();
                check("xfer_data", ex_data, popped);
            end
        end
        last_ack0 = e0;
        last_ack1 = e1;
        @(posedge clk);
        if (m_valid && !lock) m_issue = (m_issue + 1) % 65536;
        if (m_valid && lock && m_stall < 255) m_stall++;
        if (free) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_rr    = 1'b0;
            m_state = 2'd0;
            exp_q.delete();
        end else if (ld) begin
            if (any) begin
                m_valid = 1'b1;
                m_data  = wb;
                m_rr    = !win;
                m_state = 2'd1;
                exp_q.push_back(wb);
            end else begin
                m_valid = 1'b0;
                m_state = 2'd0;
            end
        end else begin
            m_state = 2'd2;
        end
        #1;
        check("ex_valid", {95'd0, ex_valid}, {95'd0, m_valid});
        check("ex_data", ex_data, m_data);
        check("state", {94'd0, state}, {94'd0, m_state});
        check("issue_count", {80'd0, issue_count}, m_issue[95:0]);
        check("stall_count", {88'd0, stall_count}, m_stall[95:0]);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        free   = 1'b0;
        lock   = 1'b0;
        req0_v = 1'b0;
        req1_v = 1'b0;
        req0_d = '0;
        req1_d = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_inputs();
        do_reset();

        // Alternating grants with both requesters permanently valid.
        req0_v = 1'b1; req0_d = make_bundle(6'h01);
        req1_v = 1'b1; req1_d = make_bundle(6'h02);
        for (int i = 0; i < 4; i++) begin
            step();
            check("rr_ack0", {95'd0, last_ack0}, {95'd0, (i % 2) == 0});
            check("rr_tag", {90'd0, ex_data[95:90]}, (i % 2 == 0) ? 96'h01 : 96'h02);
        end
        req0_v = 1'b0; req1_v = 1'b0;
        step();
        check("rr_issue4", {80'd0, issue_count}, 96'd4);

        // Lock stall then release with an immediate refill.
        idle_inputs();
        do_reset();
        req0_v = 1'b1; req0_d = make_bundle(6'h05);
        step();
        req0_v = 1'b0; lock = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("stall_state", {94'd0, state}, 96'd2);
        check("stall_tag", {90'd0, ex_data[95:90]}, 96'h05);
        check("stall_cnt3", {88'd0, stall_count}, 96'd3);
        lock = 1'b0; req1_v = 1'b1; req1_d = make_bundle(6'h06);
        step();
        check("refill_tag", {90'd0, ex_data[95:90]}, 96'h06);
        check("refill_issue", {80'd0, issue_count}, 96'd1);

        // Flush during stall resets round-robin to requester 0.
        idle_inputs();
        do_reset();
        req0_v = 1'b1; req0_d = make_bundle(6'h10);
        step();
        req1_v = 1'b1; req1_d = make_bundle(6'h11);
        req0_d = make_bundle(6'h12);
        lock = 1'b1;
        step();
        free = 1'b1;
        step();
        check("flush_valid", {95'd0, ex_valid}, 96'd0);
        check("flush_state", {94'd0, state}, 96'd0);
        free = 1'b0;
        step();
        check("flush_ack0", {95'd0, last_ack0}, 96'd1);

        // Stall counter saturation.
        idle_inputs();
        do_reset();
        req1_v = 1'b1; req1_d = make_bundle(6'h20);
        step();
        req1_v = 1'b0; lock = 1'b1;
        for (int i = 0; i < 300; i++) step();
        check("stall_sat", {88'd0, stall_count}, 96'hFF);

        // Asynchronous reset while an op is issued.
        idle_inputs();
        do_reset();
        req0_v = 1'b1; req0_d = make_bundle(6'h30);
        step();
        check("pre_async_state", {94'd0, state}, 96'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req0_v = 1'b0;

        // Random traffic with locks and occasional flushes.
        for (int i = 0; i < 3000; i++) begin
            lock = ($urandom_range(0, 9) < 3);
            free = ($urandom_range(0, 29) == 0);
            step();
            if (last_ack0 || !req0_v) begin
                req0_v = ($urandom_range(0, 3) != 0);
                req0_d = make_bundle(6'($urandom_range(0, 63)));
            end
            if (last_ack1 || !req1_v) begin
                req1_v = ($urandom_range(0, 3) != 0);
                req1_d = make_bundle(6'($urandom_range(0, 63)));
            end
        end

        // Issue counter wrap after 65535 transfers.
        idle_inputs();
        do_reset();
        req0_v = 1'b1; req0_d = make_bundle(6'h3A);
        req1_v = 1'b1; req1_d = make_bundle(6'h3B);
        for (int i = 0; i < 65536; i++) step();
        check("issue_ffff", {80'd0, issue_count}, 96'hFFFF);
        step();
        check("issue_wrap", {80'd0, issue_count}, 96'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
